conv_layer_sequencer: RTL and testbench

Sequences one convolution layer pass on the convolution datapath. Streams filter weights and biases from a parameter source into the convolution block's weight and bias memories, then gates the feature input stream into the block. Counts output features and signals layer completion. Sits between the layer-level network controller and the convolution instance.

---
 rtl/conv_layer_sequencer.sv | 204 ++++++++++++++++++++
 tb/tb_conv_layer_sequencer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_layer_sequencer.sv
// conv_layer_sequencer: sequences one convolution layer pass.
//   Loads filter weights (o,i,r,c order, c fastest) and then biases from a
//   valid/ready parameter source into the convolution block's weight/bias
//   memories. It then gates the upstream feature stream into the block and
//   passes the block's output stream downstream, counting both streams until
//   the layer is complete.
// Ports:
//   clock, reset        rising-edge clock, asynchronous active-high reset
//   start, busy, done   layer-level control (done is a one-cycle pulse)
//   prm_*               parameter word source (valid/ready/data)
//   wmem_*, bmem_*      registered weight/bias memory write ports
//   src_* -> cin_*      feature input stream into the convolution block
//   cout_* -> snk_*     convolution output stream to the downstream consumer
// Optional build macro: CONV_LAYER_SEQ_WEIGHT_REUSE_EN adds input
//   reuse_weights. When it is sampled high with start, the pass skips
//   parameter loading and goes straight to streaming.
module conv_layer_sequencer #(
  parameter int unsigned IMAGE_HEIGHT  = 10,
  parameter int unsigned IMAGE_WIDTH   = 10,
  parameter int unsigned FILTER_HEIGHT = 3,
  parameter int unsigned FILTER_WIDTH  = 3,
  parameter int unsigned INPUT_IMAGES  = 1,
  parameter int unsigned OUTPUT_IMAGES = 1,
  parameter int unsigned WEIGHT_BITS   = 16,
  parameter int unsigned FEATURE_BITS  = 16,
  localparam int unsigned OB = (OUTPUT_IMAGES > 1) ? $clog2(OUTPUT_IMAGES) : 1,
  localparam int unsigned IB = (INPUT_IMAGES > 1) ? $clog2(INPUT_IMAGES) : 1,
  localparam int unsigned RB = (FILTER_HEIGHT > 1) ? $clog2(FILTER_HEIGHT) : 1,
  localparam int unsigned CB = (FILTER_WIDTH > 1) ? $clog2(FILTER_WIDTH) : 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
`ifdef CONV_LAYER_SEQ_WEIGHT_REUSE_EN
  input  logic                    reuse_weights,
`endif
  output logic                    busy,
  output logic                    done,
  input  logic                    prm_valid,
  output logic                    prm_ready,
  input  logic [WEIGHT_BITS-1:0]  prm_data,
  output logic                    wmem_we,
  output logic [OB-1:0]           wmem_o,
  output logic [IB-1:0]           wmem_i,
  output logic [RB-1:0]           wmem_r,
  output logic [CB-1:0]           wmem_c,
  output logic [WEIGHT_BITS-1:0]  wmem_data,
  output logic                    bmem_we,
  output logic [OB-1:0]           bmem_o,
  output logic [WEIGHT_BITS-1:0]  bmem_data,
  input  logic                    src_valid,
  output logic                    src_ready,
  input  logic [FEATURE_BITS-1:0] src_data,
  output logic                    cin_valid,
  input  logic                    cin_ready,
  output logic [FEATURE_BITS-1:0] cin_data,
  input  logic                    cout_valid,
  output logic                    cout_ready,
  input  logic [FEATURE_BITS-1:0] cout_data,
  output logic                    snk_valid,
  input  logic                    snk_ready,
  output logic [FEATURE_BITS-1:0] snk_data
);

  localparam int unsigned NI  = INPUT_IMAGES * IMAGE_HEIGHT * IMAGE_WIDTH;
  localparam int unsigned NO  = OUTPUT_IMAGES * IMAGE_HEIGHT * IMAGE_WIDTH;
  localparam int unsigned NIB = $clog2(NI + 1);
  localparam int unsigned NOB = $clog2(NO + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_W, S_LOAD_B, S_STREAM, S_DRAIN, S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [OB-1:0]  w_o;
  logic [IB-1:0]  w_i;
  logic [RB-1:0]  w_r;
  logic [CB-1:0]  w_c;
  logic [OB-1:0]  b_o;
  logic [NIB-1:0] in_cnt;
  logic [NOB-1:0] out_cnt;

  logic prm_acc, in_hs, out_hs;
  logic w_c_end, w_r_end, w_i_end, w_o_end;
  logic w_last, b_last, in_last, out_full, out_done, reuse;

`ifdef CONV_LAYER_SEQ_WEIGHT_REUSE_EN
  assign reuse = reuse_weights;
`else
  assign reuse = 1'b0;
`endif

  assign prm_acc  = prm_valid & prm_ready;
  assign in_hs    = cin_valid & cin_ready;
  assign out_hs   = snk_valid & snk_ready;

  assign w_c_end  = (w_c == CB'(FILTER_WIDTH - 1));
  assign w_r_end  = (w_r == RB'(FILTER_HEIGHT - 1));
  assign w_i_end  = (w_i == IB'(INPUT_IMAGES - 1));
  assign w_o_end  = (w_o == OB'(OUTPUT_IMAGES - 1));
  assign w_last   = w_c_end & w_r_end & w_i_end & w_o_end;
  assign b_last   = (b_o == OB'(OUTPUT_IMAGES - 1));
  assign in_last  = in_hs & (in_cnt == NIB'(NI - 1));
  assign out_full = (out_cnt == NOB'(NO));
  // Output side is complete either already or with this cycle's handshake.
  assign out_done = out_full | (out_hs & (out_cnt == NOB'(NO - 1)));

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = reuse ? S_STREAM : S_LOAD_W;
      S_LOAD_W: if (prm_acc && w_last) state_nxt = S_LOAD_B;
      S_LOAD_B: if (prm_acc && b_last) state_nxt = S_STREAM;
      S_STREAM: if (in_last) state_nxt = out_done ? S_DONE : S_DRAIN;
      S_DRAIN:  if (out_done) state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Combinational control and stream gating.
  always_comb begin
    busy       = (state != S_IDLE);
    done       = (state == S_DONE);
    prm_ready  = (state == S_LOAD_W) || (state == S_LOAD_B);
    cin_valid  = 1'b0;
    src_ready  = 1'b0;
    cin_data   = '0;
    snk_valid  = 1'b0;
    cout_ready = 1'b0;
    snk_data   = '0;
    if (state == S_STREAM) begin
      cin_valid = src_valid;
      src_ready = cin_ready;
      cin_data  = src_data;
    end
    if ((state == S_STREAM) || (state == S_DRAIN)) begin
      snk_data = cout_data;
      // Outputs beyond the expected count are refused.
      if (!out_full) begin
        snk_valid  = cout_valid;
        cout_ready = snk_ready;
      end
    end
  end

  // Weight/bias address counters and stream counters.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      w_o <= '0; w_i <= '0; w_r <= '0; w_c <= '0; b_o <= '0;
      in_cnt <= '0; out_cnt <= '0;
    end else if ((state == S_IDLE) && start) begin
      w_o <= '0; w_i <= '0; w_r <= '0; w_c <= '0; b_o <= '0;
      in_cnt <= '0; out_cnt <= '0;
    end else begin
      if ((state == S_LOAD_W) && prm_acc) begin
        // Nested wrap c -> r -> i -> o.
        w_c <= w_c_end ? '0 : w_c + CB'(1);
        if (w_c_end) begin
          w_r <= w_r_end ? '0 : w_r + RB'(1);
          if (w_r_end) begin
            w_i <= w_i_end ? '0 : w_i + IB'(1);
            if (w_i_end) w_o <= w_o_end ? '0 : w_o + OB'(1);
          end
        end
      end
      if ((state == S_LOAD_B) && prm_acc) b_o <= b_last ? '0 : b_o + OB'(1);
      if (in_hs)  in_cnt  <= in_cnt + NIB'(1);
      if (out_hs) out_cnt <= out_cnt + NOB'(1);
    end
  end

  // Registered memory write ports, one cycle after each accepted word.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wmem_we <= 1'b0; wmem_o <= '0; wmem_i <= '0; wmem_r <= '0; wmem_c <= '0;
      wmem_data <= '0;
      bmem_we <= 1'b0; bmem_o <= '0; bmem_data <= '0;
    end else begin
      wmem_we <= (state == S_LOAD_W) && prm_acc;
      bmem_we <= (state == S_LOAD_B) && prm_acc;
      if ((state == S_LOAD_W) && prm_acc) begin
        wmem_o    <= w_o;
        wmem_i    <= w_i;
        wmem_r    <= w_r;
        wmem_c    <= w_c;
        wmem_data <= prm_data;
      end
      if ((state == S_LOAD_B) && prm_acc) begin
        bmem_o    <= b_o;
        bmem_data <= prm_data;
      end
    end
  end

endmodule

// File: tb/tb_conv_layer_sequencer.sv
// Self-checking bench for conv_layer_sequencer at default parameters.
// A transaction-level model (pass phase, accepted-word count, stream counts)
// predicts every output each cycle; literal expectations pin write addresses,
// data ordering and the reset behaviour.
module tb_conv_layer_sequencer;
  localparam int IH = 10, IW = 10, FH = 3, FW = 3, NIN = 1, NOUT = 1;
  localparam int NW = NOUT * NIN * FH * FW;
  localparam int NB = NOUT;
  localparam int NPRM = NW + NB;
  localparam int NI = NIN * IH * IW;
  localparam int NO = NOUT * IH * IW;

  logic        clock = 1'b0;
  logic        reset, start;
`ifdef CONV_LAYER_SEQ_WEIGHT_REUSE_EN
  logic        reuse_weights;
`endif
  logic        busy, done;
  logic        prm_valid, prm_ready;
  logic [15:0] prm_data;
  logic        wmem_we;
  logic [0:0]  wmem_o, wmem_i;
  logic [1:0]  wmem_r, wmem_c;
  logic [15:0] wmem_data;
  logic        bmem_we;
  logic [0:0]  bmem_o;
  logic [15:0] bmem_data;
  logic        src_valid, src_ready, cin_valid, cin_ready;
  logic [15:0] src_data, cin_data;
  logic        cout_valid, cout_ready, snk_valid, snk_ready;
  logic [15:0] cout_data, snk_data;

  always #5 clock = ~clock;

  conv_layer_sequencer dut (
    .clock(clock), .reset(reset), .start(start),
`ifdef CONV_LAYER_SEQ_WEIGHT_REUSE_EN
    .reuse_weights(reuse_weights),
`endif
    .busy(busy), .done(done),
    .prm_valid(prm_valid), .prm_ready(prm_ready), .prm_data(prm_data),
    .wmem_we(wmem_we), .wmem_o(wmem_o), .wmem_i(wmem_i), .wmem_r(wmem_r),
    .wmem_c(wmem_c), .wmem_data(wmem_data),
    .bmem_we(bmem_we), .bmem_o(bmem_o), .bmem_data(bmem_data),
    .src_valid(src_valid), .src_ready(src_ready), .src_data(src_data),
    .cin_valid(cin_valid), .cin_ready(cin_ready), .cin_data(cin_data),
    .cout_valid(cout_valid), .cout_ready(cout_ready), .cout_data(cout_data),
    .snk_valid(snk_valid), .snk_ready(snk_ready), .snk_data(snk_data)
  );

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // phase: 0 idle, 1 active pass, 2 completion cycle
  int m_phase, m_acc, m_in, m_out, m_widx, m_bidx;
  bit m_wpend, m_bpend;
  logic [15:0] m_pdata;
  bit po, io, oo;

  function automatic bit prm_open();
    return (m_phase == 1) && (m_acc < NPRM);
  endfunction
  function automatic bit in_open();
    return (m_phase == 1) && (m_acc >= NPRM) && (m_in < NI);
  endfunction
  function automatic bit out_open();
    return (m_phase == 1) && (m_acc >= NPRM) && (m_out < NO);
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_phase = 0; m_acc = 0; m_in = 0; m_out = 0;
      m_wpend = 0; m_bpend = 0; m_widx = 0; m_bidx = 0; m_pdata = '0;
    end else begin
      po = prm_open(); io = in_open(); oo = out_open();
      m_wpend = 0; m_bpend = 0;
      if (m_phase == 0) begin
        if (start) begin
          m_phase = 1; m_acc = 0; m_in = 0; m_out = 0;
`ifdef CONV_LAYER_SEQ_WEIGHT_REUSE_EN
          if (reuse_weights) m_acc = NPRM;
`endif
        end
      end else if (m_phase == 2) begin
        m_phase = 0;
      end else begin
        if (po && prm_valid) begin
          if (m_acc < NW) begin m_wpend = 1; m_widx = m_acc; end
          else begin m_bpend = 1; m_bidx = m_acc - NW; end
          m_pdata = prm_data;
          m_acc++;
        end
        if (io && src_valid && cin_ready) m_in++;
        if (oo && cout_valid && snk_ready) m_out++;
        if (m_in == NI && m_out == NO) m_phase = 2;
      end
    end
  end

  // ---------------- per-cycle compare and logging ----------------
  logic [31:0] wlog[$];
  logic [31:0] blog[$];
  logic [15:0] cin_log[$];
  logic [15:0] snk_log[$];
  int total_done = 0;

  always @(negedge clock) begin
    chk("busy", 32'(busy), 32'(m_phase != 0));
    chk("done", 32'(done), 32'(m_phase == 2));
    chk("prm_ready", 32'(prm_ready), 32'(prm_open()));
    chk("wmem_we", 32'(wmem_we), 32'(m_wpend));
    if (m_wpend) begin
      chk("wmem_o", 32'(wmem_o), 32'(m_widx / (NIN * FH * FW)));
      chk("wmem_i", 32'(wmem_i), 32'((m_widx / (FH * FW)) % NIN));
      chk("wmem_r", 32'(wmem_r), 32'((m_widx / FW) % FH));
      chk("wmem_c", 32'(wmem_c), 32'(m_widx % FW));
      chk("wmem_data", 32'(wmem_data), 32'(m_pdata));
    end
    chk("bmem_we", 32'(bmem_we), 32'(m_bpend));
    if (m_bpend) begin
      chk("bmem_o", 32'(bmem_o), 32'(m_bidx));
      chk("bmem_data", 32'(bmem_data), 32'(m_pdata));
    end
    chk("src_ready", 32'(src_ready), 32'(in_open() ? cin_ready : 1'b0));
    chk("cin_valid", 32'(cin_valid), 32'(in_open() ? src_valid : 1'b0));
    if (in_open()) chk("cin_data", 32'(cin_data), 32'(src_data));
    chk("cout_ready", 32'(cout_ready), 32'(out_open() ? snk_ready : 1'b0));
    chk("snk_valid", 32'(snk_valid), 32'(out_open() ? cout_valid : 1'b0));
    if (out_open()) chk("snk_data", 32'(snk_data), 32'(cout_data));

    if (wmem_we) wlog.push_back(32'({wmem_o, wmem_i, wmem_r, wmem_c, wmem_data}));
    if (bmem_we) blog.push_back(32'({bmem_o, bmem_data}));
    if (cin_valid && cin_ready) cin_log.push_back(cin_data);
    if (snk_valid && snk_ready) snk_log.push_back(snk_data);
    if (done) total_done++;
  end

  // ---------------- stimulus ----------------
  task automatic run_pass(input bit toggle, input int abort_at, input bit reuse,
                          output bit got_done);
    int pi, si, oi;
    pi = 0; si = 0; oi = 0; got_done = 0;
    wlog.delete(); blog.delete(); cin_log.delete(); snk_log.delete();
    @(posedge clock); #1;
    start = 1'b1; prm_valid = 1'b0; src_valid = 1'b0; cout_valid = 1'b0;
`ifdef CONV_LAYER_SEQ_WEIGHT_REUSE_EN
    reuse_weights = reuse;
`else
    if (reuse) $display("note: weight reuse not built in, loading normally");
`endif
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clock); #1;
      start = 1'b0;
      // After the load, keep offering junk words: they must never be taken.
      prm_valid  = (pi < NPRM) ? (!toggle || (cyc % 2 == 0)) : 1'b1;
      prm_data   = (pi < NW) ? 16'(16'h0100 + pi) : ((pi < NPRM) ? 16'h0000 : 16'hDEAD);
      src_valid  = (si < NI);
      src_data   = 16'(16'h5000 + si);
      cin_ready  = ((cyc % 3) != 2);
      cout_valid = (oi < NO) && (cyc >= 3);
      cout_data  = 16'(16'hA000 + oi);
      snk_ready  = ($urandom_range(0, 3) != 0);
      @(negedge clock);
      if (prm_valid && prm_ready) pi++;
      if (src_valid && src_ready) si++;
      if (snk_valid && snk_ready) oi++;
      if (abort_at >= 0 && pi == abort_at) break;
      if (done) begin got_done = 1; break; end
    end
  endtask

  task automatic check_stream_logs();
    chk("cin_count", 32'(cin_log.size()), 32'(NI));
    chk("snk_count", 32'(snk_log.size()), 32'(NO));
    for (int k = 0; k < cin_log.size(); k++) chk("cin_order", 32'(cin_log[k]), 32'(16'h5000 + k));
    for (int k = 0; k < snk_log.size(); k++) chk("snk_order", 32'(snk_log[k]), 32'(16'hA000 + k));
  endtask

  task automatic check_load_logs();
    chk("wmem_writes", 32'(wlog.size()), 32'd9);
    if (wlog.size() == 9) begin
      chk("wlog0", wlog[0], 32'h0000_0100);   // (0,0,0,0) 0x0100
      chk("wlog4", wlog[4], 32'h0005_0104);   // (0,0,1,1) 0x0104
      chk("wlog8", wlog[8], 32'h000A_0108);   // (0,0,2,2) 0x0108
    end
    chk("bmem_writes", 32'(blog.size()), 32'd1);
    if (blog.size() == 1) chk("blog0", blog[0], 32'h0);
  endtask

  bit got;
  int exp_done;

  initial begin
    reset = 1'b1; start = 1'b0; prm_valid = 1'b0; prm_data = '0;
    src_valid = 1'b0; src_data = '0; cin_ready = 1'b0;
    cout_valid = 1'b0; cout_data = '0; snk_ready = 1'b0;
`ifdef CONV_LAYER_SEQ_WEIGHT_REUSE_EN
    reuse_weights = 1'b0;
`endif
    exp_done = 0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_prm_ready", 32'(prm_ready), 32'd0);
    chk("rst_wmem_we", 32'(wmem_we), 32'd0);
    chk("rst_bmem_we", 32'(bmem_we), 32'd0);
    chk("rst_cin_valid", 32'(cin_valid), 32'd0);
    chk("rst_snk_valid", 32'(snk_valid), 32'd0);
    reset = 1'b0;

    // Pass 1: continuous parameter words.
    run_pass(1'b0, -1, 1'b0, got);
    chk("pass1_done", 32'(got), 32'd1);
    exp_done++;
    check_load_logs();
    check_stream_logs();

    // Pass 2: back-to-back start, parameter valid every other cycle.
    run_pass(1'b1, -1, 1'b0, got);
    chk("pass2_done", 32'(got), 32'd1);
    exp_done++;
    check_load_logs();
    check_stream_logs();

    // Pass 3: reset lands right after the 5th weight is accepted.
    run_pass(1'b0, 5, 1'b0, got);
    @(posedge clock); #1;
    chk("prerst_wmem_we", 32'(wmem_we), 32'd1);
    chk("prerst_wmem_c", 32'(wmem_c), 32'd1);
    chk("prerst_wmem_data", 32'(wmem_data), 32'h0104);
    reset = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_prm_ready", 32'(prm_ready), 32'd0);
    chk("midrst_wmem_we", 32'(wmem_we), 32'd0);
    chk("midrst_wmem_r", 32'(wmem_r), 32'd0);
    chk("midrst_wmem_c", 32'(wmem_c), 32'd0);
    chk("midrst_wmem_data", 32'(wmem_data), 32'd0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    // Pass 4: full reload after the interrupted pass.
    run_pass(1'b0, -1, 1'b0, got);
    chk("pass4_done", 32'(got), 32'd1);
    exp_done++;
    check_load_logs();
    check_stream_logs();

`ifdef CONV_LAYER_SEQ_WEIGHT_REUSE_EN
    // Pass 5: reuse weights, no loading at all.
    run_pass(1'b0, -1, 1'b1, got);
    chk("pass5_done", 32'(got), 32'd1);
    exp_done++;
    chk("reuse_wmem_writes", 32'(wlog.size()), 32'd0);
    chk("reuse_bmem_writes", 32'(blog.size()), 32'd0);
    check_stream_logs();
`endif

    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("done_pulses", 32'(total_done), 32'(exp_done));
    chk("idle_busy", 32'(busy), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
